// File: rtl/seq_shifter.sv
// Multi-cycle XLEN-wide shifter (SLL/SRL/SRA) that moves up to STEP bits per clock behind a start/busy/done handshake.
// Build option: define SEQ_SHIFTER_ROT_EN to make op 2'b11 a rotate right; otherwise 2'b11 behaves as SRL.
module seq_shifter #(
  parameter int  XLEN = 32,
  parameter int  STEP = 1,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  input  logic [1:0]      op,
  output logic [XLEN-1:0] r,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SEQ_SHIFTER_ROT_EN
  localparam logic [1:0] OP_ROR = 2'b11;
  localparam logic [SHW:0] XLEN_W = (SHW+1)'(XLEN);
`endif
  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [SHW-1:0]  count_q, count_d;
  logic [1:0]      op_q, op_d;

  logic [SHW-1:0]  k;
  logic [XLEN-1:0] shift_res;

  // Bits moved this cycle: never more than what is left, so count cannot wrap.
  always_comb begin
    k = (count_q < STEP_W) ? count_q : STEP_W;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shift_res = r_q >> k;
    case (op_q)
      OP_SLL:  shift_res = r_q << k;
      OP_SRL:  shift_res = r_q >> k;
      OP_SRA:  shift_res = $signed(r_q) >>> k;
`ifdef SEQ_SHIFTER_ROT_EN
      OP_ROR:  shift_res = (r_q >> k) | (r_q << (XLEN_W - {1'b0, k}));
`endif
      default: shift_res = r_q >> k;
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    count_d = count_q;
    op_d    = op_q;
    if (flush) begin
      // Abort wins over everything; r is left as-is and must be ignored by consumers.
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_d     = a;
            count_d = shamt;
            op_d    = op;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (count_q == '0) begin
            state_d = S_DONE;
          end else begin
            r_d     = shift_res;
            count_d = count_q - k;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      count_q <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign r    = r_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one STEP=1 and one STEP=4 instance, table-driven vectors plus reset/back-to-back/flush sequences.
module tb_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start_i [2];
  logic        flush_i [2];
  logic [31:0] a_i     [2];
  logic [4:0]  shamt_i [2];
  logic [1:0]  op_i    [2];
  logic [31:0] r_o     [2];
  logic        busy_o  [2];
  logic        done_o  [2];

  int n_pass;
  int n_total;

  seq_shifter #(.XLEN(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_i[0]), .flush(flush_i[0]), .a(a_i[0]),
    .shamt(shamt_i[0]), .op(op_i[0]), .r(r_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  seq_shifter #(.XLEN(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start_i[1]), .flush(flush_i[1]), .a(a_i[1]),
    .shamt(shamt_i[1]), .op(op_i[1]), .r(r_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, returning the number of edges after the accepting edge (bounded).
  task automatic wait_done(input int idx, output int n);
    n = 0;
    while (!done_o[idx] && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name, input int idx, input logic [1:0] op,
                        input logic [31:0] a, input logic [4:0] shamt, input logic [31:0] exp_r);
    int n;
    int step;
    step = (idx == 0) ? 1 : 4;
    op_i[idx]    = op;
    a_i[idx]     = a;
    shamt_i[idx] = shamt;
    start_i[idx] = 1'b1;
    tick();
    start_i[idx] = 1'b0;
    // Scramble inputs after acceptance: the captured copies must be used.
    a_i[idx]     = ~a;
    shamt_i[idx] = shamt ^ 5'h15;
    op_i[idx]    = ~op;
    check({name, " busy"}, 32'(busy_o[idx]), 32'd1);
    wait_done(idx, n);
    check({name, " latency"}, n, (int'(shamt) + step - 1) / step + 1);
    check({name, " r"}, r_o[idx], exp_r);
    check({name, " busy@done"}, 32'(busy_o[idx]), 32'd0);
    tick();
    check({name, " done pulse"}, 32'(done_o[idx]), 32'd0);
    check({name, " r hold"}, r_o[idx], exp_r);
  endtask

  initial begin
    int n;
    int seen_done;
    logic [31:0] ror_exp;
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; flush_i[i] = 1'b0; a_i[i] = '0; shamt_i[i] = '0; op_i[i] = 2'b00;
    end

`ifdef SEQ_SHIFTER_ROT_EN
    ror_exp = 32'h1000_000F;
`else
    ror_exp = 32'h0000_000F;
`endif
    vecs[0]  = '{0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{0, 2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001};
    vecs[2]  = '{1, 2'b10, 32'h8000_0000, 5'd7,  32'hFF00_0000};
    vecs[3]  = '{1, 2'b01, 32'h8000_0000, 5'd7,  32'h0100_0000};
    vecs[4]  = '{0, 2'b10, 32'h8000_1234, 5'd4,  32'hF800_0123};
    vecs[5]  = '{1, 2'b00, 32'hDEAD_BEEF, 5'd13, 32'hB7DD_E000};
    vecs[6]  = '{1, 2'b10, 32'h7FFF_0000, 5'd31, 32'h0000_0000};
    vecs[7]  = '{1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[8]  = '{0, 2'b01, 32'hF000_0000, 5'd3,  32'h1E00_0000};
    vecs[9]  = '{1, 2'b11, 32'h0000_00F1, 5'd4,  ror_exp};
    vecs[10] = '{0, 2'b11, 32'h0000_00F1, 5'd4,  ror_exp};
    vecs[11] = '{1, 2'b01, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};

    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset r[%0d]", i), r_o[i], 32'h0);
      check($sformatf("reset busy[%0d]", i), 32'(busy_o[i]), 32'd0);
      check($sformatf("reset done[%0d]", i), 32'(done_o[i]), 32'd0);
    end
    #2 rst = 1'b0;
    tick();

    for (int v = 0; v < 12; v++)
      run_op($sformatf("vec%0d", v), vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].shamt, vecs[v].exp_r);

    // Asynchronous reset in the middle of a shift.
    op_i[0] = 2'b10; a_i[0] = 32'hF000_0000; shamt_i[0] = 5'd20; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    repeat (5) tick();
    check("pre-rst busy", 32'(busy_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst r", r_o[0], 32'h0);
    check("async rst busy", 32'(busy_o[0]), 32'd0);
    check("async rst done", 32'(done_o[0]), 32'd0);
    tick();
    #2 rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_o[0] || busy_o[0]) seen_done++;
    end
    check("no done after rst", seen_done, 0);

    // Back-to-back: start held through DONE; start during SHIFT must be ignored.
    op_i[0] = 2'b01; a_i[0] = 32'hFFFF_FFFF; shamt_i[0] = 5'd4; start_i[0] = 1'b1;
    tick();
    shamt_i[0] = 5'd8;
    wait_done(0, n);
    check("b2b first latency", n, 5);
    check("b2b first r", r_o[0], 32'h0FFF_FFFF);
    tick();
    start_i[0] = 1'b0;
    check("b2b restart busy", 32'(busy_o[0]), 32'd1);
    check("b2b restart done", 32'(done_o[0]), 32'd0);
    wait_done(0, n);
    check("b2b second latency", n, 9);
    check("b2b second r", r_o[0], 32'h00FF_FFFF);
    tick();
    check("b2b single pulse", 32'(done_o[0]), 32'd0);

    // Flush in the third SHIFT cycle, with start also raised.
    op_i[0] = 2'b00; a_i[0] = 32'h0000_0003; shamt_i[0] = 5'd16; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    tick();
    tick();
    flush_i[0] = 1'b1; start_i[0] = 1'b1;
    tick();
    flush_i[0] = 1'b0; start_i[0] = 1'b0;
    check("flush busy", 32'(busy_o[0]), 32'd0);
    check("flush done", 32'(done_o[0]), 32'd0);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_o[0] || busy_o[0]) seen_done++;
    end
    check("flush start dropped", seen_done, 0);
    run_op("post-flush", 0, 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
